clock_compare_counter: RTL and testbench

Gated edge-counter core that measures an asynchronous test clock against `ACLK`. It counts synchronised rising edges of `test_clk_i` over a programmable window of `ACLK` cycles. It sits directly upstream of the clockComparison AXI4-Lite register bank: the register bank drives `window_i`, `start_i`, `continuous_i` and `abort_i`, and captures `result_o` on `result_valid_o`.

---
 rtl/clock_compare_pkg.sv | 14 +
 rtl/clock_compare_edge_sync.sv | 31 +++
 rtl/clock_compare_counter.sv | 152 +++++++++++++++
 tb/tb_clock_compare_counter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_compare_pkg.sv
`timescale 1ns/1ps
// Shared types and defaults for the clock comparison counter.
// State encoding and default measurement width.
package clock_compare_pkg;

  localparam int CC_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } cc_state_e;

endpackage

// File: rtl/clock_compare_edge_sync.sv
`timescale 1ns/1ps
// Synchronises test_clk_i into ACLK and emits a one-cycle rising-edge strobe.
// Strobe appears SYNC_STAGES+1 cycles after the rise; no backpressure.
module clock_compare_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic test_clk_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic                   r_edge;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], test_clk_i};
      r_dly  <= r_sync[SYNC_STAGES-1];
      r_edge <= r_sync[SYNC_STAGES-1] & ~r_dly;
    end
  end

  assign edge_o = r_edge;

endmodule

// File: rtl/clock_compare_counter.sv
`timescale 1ns/1ps
// Gated edge counter: result one cycle after the final gate cycle; no backpressure.
// CLOCK_COMPARISON_DRIFT_EN adds expected/tolerance compare with registered mismatch_o.
module clock_compare_counter
  import clock_compare_pkg::*;
#(
  parameter int CNT_W       = CC_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             test_clk_i,
  input  logic             start_i,
  input  logic             continuous_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] window_i,
  output logic [CNT_W-1:0] result_o,
  output logic             result_valid_o,
  output logic             busy_o,
  output logic             overflow_o,
`ifdef CLOCK_COMPARISON_DRIFT_EN
  input  logic [CNT_W-1:0] expected_i,
  input  logic [CNT_W-1:0] tolerance_i,
  output logic             mismatch_o,
`endif
  output logic             cfg_err_o
);

  cc_state_e        r_state;
  cc_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [CNT_W-1:0] r_result;
  logic             r_ovf;
  logic             r_overflow;
  logic             r_result_vld;
  logic             r_cfg_err;
  logic             w_edge;
  logic             w_final;
  logic             w_win_zero;
  logic             w_sat;
  logic [CNT_W-1:0] w_cnt_now;
  logic             w_ovf_now;

  clock_compare_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .test_clk_i (test_clk_i),
    .edge_o     (w_edge)
  );

  assign w_win_zero = (window_i == '0);
  assign w_final    = (r_state == COUNT) && (r_gate_cnt == '0);
  assign w_sat      = &r_edge_cnt;
  // Count including this cycle's strobe, so the final-cycle edge lands in the result.
  assign w_cnt_now  = (w_edge && !w_sat) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
  assign w_ovf_now  = r_ovf | (w_edge & w_sat);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_i && !w_win_zero) w_state_nxt = ARM;
      ARM:     w_state_nxt = abort_i ? IDLE : COUNT;
      COUNT: begin
        if (abort_i)      w_state_nxt = IDLE;
        else if (w_final) w_state_nxt = (continuous_i && !w_win_zero) ? COUNT : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (r_state != IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_ovf        <= 1'b0;
      r_result     <= '0;
      r_overflow   <= 1'b0;
      r_result_vld <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_result_vld <= 1'b0;
      r_cfg_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            if (w_win_zero) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_gate_cnt <= window_i - CNT_W'(1);
              r_edge_cnt <= '0;
              r_ovf      <= 1'b0;
            end
          end
        end
        COUNT: begin
          if (!abort_i) begin
            if (w_final) begin
              r_result     <= w_cnt_now;
              r_overflow   <= w_ovf_now;
              r_result_vld <= 1'b1;
              r_edge_cnt   <= '0;
              r_ovf        <= 1'b0;
              if (continuous_i) begin
                if (w_win_zero) r_cfg_err  <= 1'b1;
                else            r_gate_cnt <= window_i - CNT_W'(1);
              end
            end else begin
              r_gate_cnt <= r_gate_cnt - CNT_W'(1);
              r_edge_cnt <= w_cnt_now;
              r_ovf      <= w_ovf_now;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o       = r_result;
  assign result_valid_o = r_result_vld;
  assign overflow_o     = r_overflow;
  assign cfg_err_o      = r_cfg_err;

`ifdef CLOCK_COMPARISON_DRIFT_EN
  logic [CNT_W:0] w_cnt_ext;
  logic [CNT_W:0] w_exp_ext;
  logic [CNT_W:0] w_diff;
  logic           r_mismatch;

  assign w_cnt_ext = {1'b0, w_cnt_now};
  assign w_exp_ext = {1'b0, expected_i};
  assign w_diff    = (w_cnt_ext >= w_exp_ext) ? w_cnt_ext - w_exp_ext : w_exp_ext - w_cnt_ext;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                r_mismatch <= 1'b0;
    else if (w_final && !abort_i) r_mismatch <= (w_diff > {1'b0, tolerance_i});
  end

  assign mismatch_o = r_mismatch;
`endif

endmodule

// File: tb/tb_clock_compare_counter.sv
`timescale 1ns/1ps
// Self-checking bench for clock_compare_counter against a recorded-rise reference model.
module tb_clock_compare_counter;

  localparam int CNT_W = 32;
  localparam int SYNC  = 2;

  logic             ACLK = 1'b0;
  logic             ARESETN = 1'b0;
  logic             test_clk = 1'b0;
  logic             start_i = 1'b0;
  logic             continuous_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [CNT_W-1:0] window_i = '0;
  logic [CNT_W-1:0] result_o;
  logic             result_valid_o;
  logic             busy_o;
  logic             overflow_o;
  logic             cfg_err_o;
`ifdef CLOCK_COMPARISON_DRIFT_EN
  logic [CNT_W-1:0] expected_i = '0;
  logic [CNT_W-1:0] tolerance_i = '0;
  logic             mismatch_o;
`endif

  real  tc_half = 20.0;
  int   cyc = 0;
  int   vld_cnt = 0;
  int   rise_q[$];
  logic tc_prev = 1'b0;
  int   tests = 0;
  int   fails = 0;

  clock_compare_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .test_clk_i     (test_clk),
    .start_i        (start_i),
    .continuous_i   (continuous_i),
    .abort_i        (abort_i),
    .window_i       (window_i),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .busy_o         (busy_o),
    .overflow_o     (overflow_o),
`ifdef CLOCK_COMPARISON_DRIFT_EN
    .expected_i     (expected_i),
    .tolerance_i    (tolerance_i),
    .mismatch_o     (mismatch_o),
`endif
    .cfg_err_o      (cfg_err_o)
  );

  always #5 ACLK = ~ACLK;

  // Test clock toggles on a quarter-ns grid so it never coincides with an ACLK edge.
  initial begin
    #0.25;
    forever #(tc_half) test_clk = ~test_clk;
  end

  // Record the ACLK edge index at which each test clock rise is first sampled.
  always @(posedge ACLK) begin
    cyc <= cyc + 1;
    if (test_clk && !tc_prev) rise_q.push_back(cyc + 1);
    tc_prev <= test_clk;
  end

  always @(negedge ACLK) if (result_valid_o) vld_cnt <= vld_cnt + 1;

  // A rise sampled at edge c strobes in the cycle starting at edge c+SYNC;
  // it is counted when that cycle is one of the gated cycles [lo, hi].
  function automatic int model_cnt(input int lo, input int hi);
    int n = 0;
    foreach (rise_q[i])
      if (rise_q[i] + SYNC >= lo && rise_q[i] + SYNC <= hi) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int w, input int nwin, input int poke);
    int s, at, bcnt, exp_cnt;
`ifdef CLOCK_COMPARISON_DRIFT_EN
    int diff;
`endif
    @(negedge ACLK);
    window_i = w; start_i = 1'b1; continuous_i = (nwin > 1); s = cyc + 1;
    @(negedge ACLK);
    start_i = 1'b0;
    bcnt = int'(busy_o);
    for (int k = 0; k < nwin; k++) begin
      continuous_i = (k < nwin - 1);
      at = -1;
      for (int i = 0; i < w + 10; i++) begin
        @(negedge ACLK);
        start_i = (poke > 0 && i == poke);
        if (result_valid_o) begin
          at = cyc;
          break;
        end
        bcnt += int'(busy_o);
      end
      start_i = 1'b0;
      exp_cnt = model_cnt(s + 1 + k * w, s + (k + 1) * w);
      check("valid_cycle", 64'(at), 64'(s + (k + 1) * w + 1));
      check("result", result_o, 64'(exp_cnt));
      check("overflow", overflow_o, 0);
      check("busy_after", busy_o, (k < nwin - 1));
      check("no_cfg_err", cfg_err_o, 0);
`ifdef CLOCK_COMPARISON_DRIFT_EN
      diff = (exp_cnt > int'(expected_i)) ? exp_cnt - int'(expected_i) : int'(expected_i) - exp_cnt;
      check("mismatch", mismatch_o, (diff > int'(tolerance_i)));
`endif
    end
    continuous_i = 1'b0;
    if (nwin == 1) check("busy_cycles", 64'(bcnt), 64'(w + 1));
  endtask

  initial begin
    int s, at, v0, w, n;
    logic [CNT_W-1:0] prev_res;

    repeat (3) @(negedge ACLK);
    check("rst_result", result_o, 0);
    check("rst_valid", result_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_cfg_err", cfg_err_o, 0);
    ARESETN = 1'b1;
    repeat (5) @(negedge ACLK);

`ifdef CLOCK_COMPARISON_DRIFT_EN
    expected_i = 250; tolerance_i = 2;
`endif
    // 40 ns test clock over 1000 cycles
    tc_half = 20.0;
    run(1000, 1, 0);
    check("spec_250", result_o, 250);

    // three back-to-back 100-cycle windows of a 50 ns clock
    tc_half = 25.0;
`ifdef CLOCK_COMPARISON_DRIFT_EN
    expected_i = 20; tolerance_i = 0;
`endif
    run(100, 3, 0);
    check("spec_20", result_o, 20);

    // abort in COUNT
    prev_res = result_o;
    @(negedge ACLK);
    window_i = 1000; start_i = 1'b1; s = cyc + 1;
    @(negedge ACLK);
    start_i = 1'b0;
    while (cyc < s + 50) @(negedge ACLK);
    abort_i = 1'b1;
    @(negedge ACLK);
    abort_i = 1'b0;
    check("abort_busy", busy_o, 0);
    v0 = vld_cnt;
    repeat (1010) @(negedge ACLK);
    check("abort_no_valid", 64'(vld_cnt), 64'(v0));
    check("abort_result_kept", result_o, prev_res);

    // zero window start
    @(negedge ACLK);
    window_i = 0; start_i = 1'b1;
    @(negedge ACLK);
    start_i = 1'b0;
    check("cfg_err_pulse", cfg_err_o, 1);
    check("cfg_err_busy", busy_o, 0);
    @(negedge ACLK);
    check("cfg_err_one_cycle", cfg_err_o, 0);
    check("cfg_err_busy_later", busy_o, 0);

    // start while busy is ignored; single-cycle windows
    tc_half = 17.5;
    run(200, 1, 30);
    run(1, 1, 0);
    run(1, 3, 0);

    // continuous reload with window 0
    @(negedge ACLK);
    window_i = 50; continuous_i = 1'b1; start_i = 1'b1; s = cyc + 1;
    @(negedge ACLK);
    start_i = 1'b0; window_i = 0;
    at = -1;
    for (int i = 0; i < 70; i++) begin
      @(negedge ACLK);
      if (result_valid_o) begin
        at = cyc;
        break;
      end
    end
    continuous_i = 1'b0;
    check("zr_valid_cycle", 64'(at), 64'(s + 51));
    check("zr_cfg_err", cfg_err_o, 1);
    check("zr_busy", busy_o, 0);
    check("zr_result", result_o, 64'(model_cnt(s + 1, s + 50)));

    // asynchronous reset mid-window
    @(negedge ACLK);
    window_i = 500; start_i = 1'b1;
    @(negedge ACLK);
    start_i = 1'b0;
    repeat (100) @(negedge ACLK);
    #2 ARESETN = 1'b0;
    #1;
    check("arst_result", result_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_valid", result_valid_o, 0);
    check("arst_overflow", overflow_o, 0);
    check("arst_cfg_err", cfg_err_o, 0);
`ifdef CLOCK_COMPARISON_DRIFT_EN
    check("arst_mismatch", mismatch_o, 0);
`endif
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (5) @(negedge ACLK);
    run(300, 1, 0);

    // randomized periods, windows and window counts
    for (int r = 0; r < 6; r++) begin
      tc_half = $urandom_range(30, 80) / 2.0;
      w = $urandom_range(3, 400);
      n = $urandom_range(1, 3);
`ifdef CLOCK_COMPARISON_DRIFT_EN
      expected_i = CNT_W'(int'(w * 5.0 / tc_half) + 2 - int'($urandom_range(0, 4)));
      tolerance_i = CNT_W'($urandom_range(0, 2));
`endif
      run(w, n, 0);
    end

`ifdef CLOCK_COMPARISON_DRIFT_EN
    expected_i = 250; tolerance_i = 2;
    tc_half = 20.5;
    run(1000, 1, 0);
    check("drift_41ns_mismatch", mismatch_o, 1);
    tc_half = 20.0;
    run(1000, 1, 0);
    check("drift_40ns_match", mismatch_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
